// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_pkg
// Description : Shared constants and types for the 4-digit 7-segment scan
//               driver: digit count, scan state encoding, blank segment code.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bus value with every segment and the decimal point dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Two-phase slot sequencer: guard blanking, then digit drive.
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage : seg7_scan_driver_pkg
`default_nettype wire

// File: rtl/bin_to_7seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_7seg_decoder
// Description : Hex nibble to active-high 7-segment code, bit0=a .. bit6=g.
// Ports       : bin [3:0] in  - nibble to decode
//               seg [6:0] out - segment pattern {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_7seg_decoder (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bin)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule : bin_to_7seg_decoder
`default_nettype wire

// File: rtl/seg7_scan_driver_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Phase counter for the scan sequencer. Counts 0..limit and
//               wraps to 0 after the terminal count; tc flags the last count.
// Ports       : clk, rstb (async active-low), ena (count enable)
//               limit [WIDTH-1:0] in  - last count value of the current phase
//               tc               out - count == limit
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == limit);

  // Wrapping on tc doubles as the clear at every phase change, because the
  // phase only ever changes on the edge where tc is high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (ena) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed 4-digit 7-segment driver with guard
//               blanking between digits and optional leading-zero
//               suppression. All outputs are registered.
// Ports       : clk           in  - system clock
//               rstb          in  - asynchronous active-low reset
//               ena           in  - clock enable, low freezes everything
//               load          in  - strobe capturing data_in/dp_in
//               data_in[15:0] in  - value, nibble i -> digit i
//               dp_in[3:0]    in  - decimal point per digit
//               lz_en         in  - leading-zero suppression enable
//               seg_out[7:0]  out - {dp,g,f,e,d,c,b,a}, active high
//               digit_en[3:0] out - one-hot digit select, active high
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        ena,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [7:0]  seg_out,
  output logic [3:0]  digit_en
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [15:0]      shadow;
  logic [3:0]       dp_sh;
  logic [1:0]       idx;
  logic [CNT_W-1:0] limit;
  logic             tc;
  logic [6:0]       hex_seg;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic             suppress;
  logic [7:0]       seg_nxt;
  logic [3:0]       digit_nxt;

  // ---------------------------------------------------------------------------
  // Phase counter
  // ---------------------------------------------------------------------------
  assign limit = (state == ST_DRIVE) ? DRIVE_LAST : BLANK_LAST;

  scan_prescaler #(
    .WIDTH (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .limit (limit),
    .tc    (tc)
  );

  // ---------------------------------------------------------------------------
  // Shadow register and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shadow <= 16'h0000;
      dp_sh  <= 4'b0000;
    end else if (ena && load) begin
      shadow <= data_in;
      dp_sh  <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx <= 2'd0;
    end else if (ena && (state == ST_DRIVE) && tc) begin
      idx <= idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode and leading-zero detection
  // ---------------------------------------------------------------------------
  bin_to_7seg_decoder u_decoder (
    .bin (shadow[{idx, 2'b00} +: 4]),
    .seg (hex_seg)
  );

  // upper_zero[i]: nibbles i..3 are all zero.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign upper_zero[i] = ~|shadow[4*NUM_DIGITS-1 : 4*i];
  end

  // Digit 0 always shows, so a zero value still displays "0".
  assign suppress = lz_en && (idx != 2'd0) && upper_zero[idx];

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_BLANK;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (tc) state_nxt = ST_DRIVE;
      ST_DRIVE: if (tc) state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  // Outputs only change at phase boundaries: loaded on BLANK->DRIVE, cleared
  // on DRIVE->BLANK, held otherwise. A load mid-DRIVE therefore cannot
  // disturb the digit being shown.
  always_comb begin
    seg_nxt   = seg_out;
    digit_nxt = digit_en;
    if (tc) begin
      if (state == ST_BLANK) begin
        if (suppress) begin
          seg_nxt   = SEG_OFF;
          digit_nxt = 4'b0000;
        end else begin
          seg_nxt   = {dp_sh[idx], hex_seg};
          digit_nxt = 4'b0001 << idx;
        end
      end else begin
        seg_nxt   = SEG_OFF;
        digit_nxt = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      seg_out  <= SEG_OFF;
      digit_en <= 4'b0000;
    end else if (ena) begin
      seg_out  <= seg_nxt;
      digit_en <= digit_nxt;
    end
  end

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               SCAN_DIV=4, BLANK_CYCLES=2 (6-clock slots, 24-clock frames).
//               Expected outputs are checked as {digit_en, seg_out}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk;
  logic        rstb;
  logic        ena;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en;

  int n_checks;
  int n_fail;

  seg7_scan_driver #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .load     (load),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .lz_en    (lz_en),
    .seg_out  (seg_out),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one 6-clock slot starting right after the previous slot ended:
  // 2 blank samples' worth around a 4-sample drive window. A load strobe can
  // be placed before edge ld_tick (1..6), 0 for none.
  task automatic run_slot(input string tag, input logic [3:0] en_exp,
                          input logic [7:0] seg_exp, input int ld_tick,
                          input logic [15:0] ld_data, input logic [3:0] ld_dp);
    for (int t = 1; t <= 6; t++) begin
      if (t == ld_tick) begin
        load    = 1'b1;
        data_in = ld_data;
        dp_in   = ld_dp;
      end
      tick();
      load = 1'b0;
      if (t == 1 || t == 6)
        check({tag, "_blank"}, {20'h0, digit_en, seg_out}, 32'h0);
      else
        check({tag, "_drive"}, {20'h0, digit_en, seg_out}, {20'h0, en_exp, seg_exp});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstb     = 1'b0;
    ena      = 1'b1;
    load     = 1'b0;
    data_in  = 16'h0;
    dp_in    = 4'h0;
    lz_en    = 1'b0;

    // 1. Reset state, then first slot shows digit 0 of an all-zero shadow.
    tick();
    tick();
    check("reset", {20'h0, digit_en, seg_out}, 32'h0);
    rstb = 1'b1;
    check("reset_release", {20'h0, digit_en, seg_out}, 32'h0);
    run_slot("rst_d0", 4'b0001, 8'h3F, 0, 16'h0, 4'h0);
    run_slot("rst_d1", 4'b0010, 8'h3F, 0, 16'h0, 4'h0);
    run_slot("rst_d2", 4'b0100, 8'h3F, 0, 16'h0, 4'h0);
    run_slot("rst_d3", 4'b1000, 8'h3F, 0, 16'h0, 4'h0);

    // 2. 0x1234 with a decimal point on digit 2, shown for two frames.
    run_slot("v1234_d0", 4'b0001, 8'h66, 1, 16'h1234, 4'b0100);
    run_slot("v1234_d1", 4'b0010, 8'h4F, 0, 16'h0, 4'h0);
    run_slot("v1234_d2", 4'b0100, 8'hDB, 0, 16'h0, 4'h0);
    run_slot("v1234_d3", 4'b1000, 8'h06, 0, 16'h0, 4'h0);
    run_slot("v1234_f2d0", 4'b0001, 8'h66, 0, 16'h0, 4'h0);
    run_slot("v1234_f2d1", 4'b0010, 8'h4F, 0, 16'h0, 4'h0);
    run_slot("v1234_f2d2", 4'b0100, 8'hDB, 0, 16'h0, 4'h0);
    run_slot("v1234_f2d3", 4'b1000, 8'h06, 0, 16'h0, 4'h0);

    // 3. Leading-zero suppression. The load lands on the latch edge, so
    //    digit 0 of this slot still shows the old nibble.
    lz_en = 1'b1;
    run_slot("ld_on_latch", 4'b0001, 8'h66, 2, 16'h0007, 4'b0000);
    run_slot("lz7_d1", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz7_d2", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz7_d3", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz7_d0", 4'b0001, 8'h07, 0, 16'h0, 4'h0);
    run_slot("lz7b_d1", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz7b_d2", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz7b_d3", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    // Zero value: digit 0 still shown, decimal points of blanked digits dark.
    run_slot("lz0_d0", 4'b0001, 8'h3F, 1, 16'h0000, 4'b1110);
    run_slot("lz0_d1", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz0_d2", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    run_slot("lz0_d3", 4'b0000, 8'h00, 0, 16'h0, 4'h0);
    lz_en = 1'b0;
    run_slot("nolz_d0", 4'b0001, 8'h3F, 0, 16'h0, 4'h0);
    run_slot("nolz_d1", 4'b0010, 8'hBF, 0, 16'h0, 4'h0);
    run_slot("nolz_d2", 4'b0100, 8'hBF, 0, 16'h0, 4'h0);
    run_slot("nolz_d3", 4'b1000, 8'hBF, 0, 16'h0, 4'h0);

    // 4. Load during digit-2 drive does not disturb the digit on display.
    run_slot("mid_d0", 4'b0001, 8'h66, 1, 16'h1234, 4'b0000);
    run_slot("mid_d1", 4'b0010, 8'h4F, 0, 16'h0, 4'h0);
    run_slot("mid_d2", 4'b0100, 8'h5B, 4, 16'hFFFF, 4'b0000);
    run_slot("mid_d3", 4'b1000, 8'h71, 0, 16'h0, 4'h0);

    // 5. Freeze mid-drive of digit 0 for 10 clocks, with an ignored load.
    tick();
    check("frz_blank", {20'h0, digit_en, seg_out}, 32'h0);
    tick();
    check("frz_latch", {20'h0, digit_en, seg_out}, {20'h0, 4'b0001, 8'h71});
    tick();
    ena     = 1'b0;
    load    = 1'b1;
    data_in = 16'h0000;
    dp_in   = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("frz_hold", {20'h0, digit_en, seg_out}, {20'h0, 4'b0001, 8'h71});
    end
    load = 1'b0;
    ena  = 1'b1;
    tick();
    check("frz_resume1", {20'h0, digit_en, seg_out}, {20'h0, 4'b0001, 8'h71});
    tick();
    check("frz_resume2", {20'h0, digit_en, seg_out}, {20'h0, 4'b0001, 8'h71});
    tick();
    check("frz_end", {20'h0, digit_en, seg_out}, 32'h0);
    run_slot("frz_d1", 4'b0010, 8'h71, 0, 16'h0, 4'h0);

    // 6. Asynchronous reset mid-drive of digit 3.
    run_slot("pre_rst_d2", 4'b0100, 8'h71, 0, 16'h0, 4'h0);
    tick();
    tick();
    tick();
    check("pre_rst_d3", {20'h0, digit_en, seg_out}, {20'h0, 4'b1000, 8'h71});
    rstb = 1'b0;
    #1;
    check("async_rst", {20'h0, digit_en, seg_out}, 32'h0);
    tick();
    rstb = 1'b1;
    run_slot("post_rst_d0", 4'b0001, 8'h3F, 0, 16'h0, 4'h0);
    run_slot("post_rst_d1", 4'b0010, 8'h3F, 0, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_driver
`default_nettype wire
